// File: rtl/scan_test_pkg.sv
// Shared types and defaults for the scan test sequencer and its MISR.
package scan_test_pkg;

    localparam int SIG_W = 16;

    localparam logic [SIG_W-1:0] DEFAULT_LFSR_SEED = 16'hACE1;
    localparam logic [SIG_W-1:0] DEFAULT_LFSR_POLY = 16'hB400;
    localparam logic [SIG_W-1:0] DEFAULT_MISR_POLY = 16'hB400;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CAPTURE,
        UNLOAD,
        WAIT_BIST,
        DONE
    } state_t;

    // Galois right-shift step used by the pattern generator.
    function automatic logic [SIG_W-1:0] lfsr_step(input logic [SIG_W-1:0] v,
                                                    input logic [SIG_W-1:0] poly);
        return (v >> 1) ^ (v[0] ? poly : '0);
    endfunction

endpackage

// File: rtl/scan_misr.sv
// Serial-input MISR that compacts returned scan data into a signature.
module scan_misr
    import scan_test_pkg::*;
#(
    parameter logic [SIG_W-1:0] POLY = DEFAULT_MISR_POLY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic             serial_in,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clear) begin
            sig_d = '0;
        end else if (enable) begin
            sig_d = {sig_q[SIG_W-2:0], 1'b0}
                  ^ (sig_q[SIG_W-1] ? POLY : '0)
                  ^ {{(SIG_W-1){1'b0}}, serial_in};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/scan_test_ctrl.sv
// Scan test sequencer: LFSR pattern load/capture, MISR unload compaction,
// then waits for core BIST and produces a single pass/fail verdict.
module scan_test_ctrl
    import scan_test_pkg::*;
#(
    parameter int               CHAIN_LEN    = 4,
    parameter int               NUM_PATTERNS = 8,
    parameter logic [SIG_W-1:0] LFSR_SEED    = DEFAULT_LFSR_SEED,
    parameter logic [SIG_W-1:0] LFSR_POLY    = DEFAULT_LFSR_POLY,
    parameter logic [SIG_W-1:0] MISR_POLY    = DEFAULT_MISR_POLY,
    parameter logic [SIG_W-1:0] GOLDEN_SIG   = 16'h0000,
    parameter int               BIST_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        scan_out,
    input  logic        bist_done,
    input  logic        bist_fail,
    output logic        scan_en,
    output logic        scan_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature,
    output logic [7:0]  pattern_cnt
);

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [SIG_W-1:0] SEED      = (LFSR_SEED == '0) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0]      LAST_BIT  = 16'(CHAIN_LEN - 1);
    localparam logic [7:0]       LAST_PAT  = 8'(NUM_PATTERNS - 1);
    localparam logic [15:0]      LAST_WAIT = 16'(BIST_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic             start_q;
    logic [SIG_W-1:0] lfsr_q, lfsr_d;
    logic [15:0]      bit_cnt_q, bit_cnt_d;
    logic [15:0]      wait_cnt_q, wait_cnt_d;
    logic [7:0]       pattern_cnt_q, pattern_cnt_d;
    logic             fail_lat_q, fail_lat_d;
    logic             timeout_q, timeout_d;
    logic             scan_en_q, scan_en_d;
    logic             scan_in_q, scan_in_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             misr_clear;
    logic             misr_en;
    logic             start_edge;
    logic [SIG_W-1:0] sig;

    assign start_edge = start & ~start_q;

    always_comb begin
        state_d       = state_q;
        lfsr_d        = lfsr_q;
        bit_cnt_d     = bit_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        pattern_cnt_d = pattern_cnt_q;
        fail_lat_d    = fail_lat_q;
        timeout_d     = timeout_q;
        misr_clear    = 1'b0;
        misr_en       = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start_edge) begin
                    state_d       = SHIFT;
                    lfsr_d        = SEED;
                    bit_cnt_d     = '0;
                    wait_cnt_d    = '0;
                    pattern_cnt_d = '0;
                    fail_lat_d    = 1'b0;
                    timeout_d     = 1'b0;
                    misr_clear    = 1'b1;
                end
            end
            SHIFT: begin
                lfsr_d = lfsr_step(lfsr_q, LFSR_POLY);
                // Pattern 0 unloads pre-test chain content, which is not compacted.
                misr_en = (pattern_cnt_q != '0);
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d = '0;
                    state_d   = CAPTURE;
                end else begin
                    bit_cnt_d = bit_cnt_q + 16'd1;
                end
            end
            CAPTURE: begin
                pattern_cnt_d = pattern_cnt_q + 8'd1;
                state_d       = (pattern_cnt_q == LAST_PAT) ? UNLOAD : SHIFT;
            end
            UNLOAD: begin
                misr_en = 1'b1;
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d  = '0;
                    wait_cnt_d = '0;
                    state_d    = WAIT_BIST;
                end else begin
                    bit_cnt_d = bit_cnt_q + 16'd1;
                end
            end
            WAIT_BIST: begin
                if (bist_done) begin
                    fail_lat_d = bist_fail;
                    state_d    = DONE;
                end else if (wait_cnt_q == LAST_WAIT) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with state_q.
        scan_en_d = (state_d == SHIFT) || (state_d == UNLOAD);
        scan_in_d = (state_d == SHIFT) && lfsr_d[0];
        busy_d    = state_d inside {SHIFT, CAPTURE, UNLOAD, WAIT_BIST};
        done_d    = (state_d == DONE);
        pass_d    = done_d && (sig == GOLDEN_SIG) && !fail_lat_d && !timeout_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            start_q       <= 1'b0;
            lfsr_q        <= SEED;
            bit_cnt_q     <= '0;
            wait_cnt_q    <= '0;
            pattern_cnt_q <= '0;
            fail_lat_q    <= 1'b0;
            timeout_q     <= 1'b0;
            scan_en_q     <= 1'b0;
            scan_in_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_q       <= start;
            lfsr_q        <= lfsr_d;
            bit_cnt_q     <= bit_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            pattern_cnt_q <= pattern_cnt_d;
            fail_lat_q    <= fail_lat_d;
            timeout_q     <= timeout_d;
            scan_en_q     <= scan_en_d;
            scan_in_q     <= scan_in_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
        end
    end

    scan_misr #(
        .POLY(MISR_POLY)
    ) u_misr (
        .clk      (clk),
        .rst      (rst),
        .clear    (misr_clear),
        .enable   (misr_en),
        .serial_in(scan_out),
        .sig      (sig)
    );

    assign scan_en     = scan_en_q;
    assign scan_in     = scan_in_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign signature   = sig;
    assign pattern_cnt = pattern_cnt_q;

endmodule

// File: doc/scan_test_ctrl.md
Name: scan_test_ctrl

Overview:
On-chip scan test sequencer that sits directly upstream of microwatt_dft. It drives the core's scan_en/scan_in with LFSR-generated patterns and compacts the returned scan_out into a MISR signature. It also collects the core's bist_done/bist_fail status. One start pulse produces one final pass/fail verdict for the whole DFT run.

Parameters:
CHAIN_LEN, 4, scan chain length in flops (>=1)
NUM_PATTERNS, 8, number of load/capture patterns (>=1)
LFSR_SEED, 16'hACE1, pattern LFSR seed (a zero seed is forced to 16'h0001)
LFSR_POLY, 16'hB400, Galois pattern polynomial (x^16+x^14+x^13+x^11+1)
MISR_POLY, 16'hB400, MISR feedback polynomial
GOLDEN_SIG, 16'h0000, expected signature (set per netlist)
BIST_TIMEOUT, 255, max cycles spent in WAIT_BIST

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  rising edge launches a run; ignored while busy
scan_out  in  1  chain output from microwatt_dft
bist_done  in  1  BIST completion from microwatt_dft
bist_fail  in  1  BIST failure from microwatt_dft, valid when bist_done=1
scan_en  out  1  scan shift enable to microwatt_dft
scan_in  out  1  serial scan data to microwatt_dft
busy  out  1  run in progress
done  out  1  verdict valid
pass  out  1  verdict: signature match, no BIST fail, no timeout
signature  out  16  current MISR value
pattern_cnt  out  8  patterns applied so far

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - scan_en=0, scan_in=0, busy=0, done=0, pass=0
  - signature=0, pattern_cnt=0, state=IDLE, LFSR=seed
- Reset asserted mid-run aborts the run immediately. No verdict is produced.
- Start detection uses the registered rising edge of start.
- States and transitions:
  - IDLE or DONE, start edge: go to SHIFT next cycle. Clear MISR, pattern_cnt, bit_cnt and done; reload the LFSR seed; set busy=1.
  - SHIFT: scan_en=1, scan_in=LFSR[0]; the LFSR advances every cycle. After CHAIN_LEN cycles go to CAPTURE.
  - CAPTURE: exactly 1 cycle with scan_en=0 and scan_in=0; pattern_cnt increments. If pattern_cnt reaches NUM_PATTERNS go to UNLOAD, else return to SHIFT.
  - UNLOAD: scan_en=1, scan_in=0 for CHAIN_LEN cycles, then go to WAIT_BIST.
  - WAIT_BIST: scan_en=0; a cycle counter runs.
    - bist_done=1: latch bist_fail and go to DONE.
    - Counter reaches BIST_TIMEOUT: set the timeout flag and go to DONE.
  - DONE: busy=0, done=1, pass=(signature==GOLDEN_SIG) && !bist_fail_latched && !timeout. Holds until the next start edge.
- MISR compaction:
  - Updates on SHIFT cycles of patterns 1..N-1 and on all UNLOAD cycles.
  - Does not update during pattern 0's SHIFT cycles (chain content is pre-test).
  - Update rule: sig <= (sig<<1) ^ (sig[15] ? MISR_POLY : 0) ^ {15'b0, scan_out}.
- LFSR: Galois right shift, lfsr <= (lfsr>>1) ^ (lfsr[0] ? LFSR_POLY : 0).
- Latency: from the first SHIFT cycle to the WAIT_BIST entry is NUM_PATTERNS*(CHAIN_LEN+1)+CHAIN_LEN cycles, which is 44 at defaults.
- Simultaneous events:
  - start edge while busy: ignored.
  - bist_done together with the timeout expiry: bist_done wins, timeout flag stays 0.
  - bist_done asserted before WAIT_BIST: not latched; sampled only in WAIT_BIST.
- All outputs are registered. signature and pattern_cnt hold their final values in DONE.

Decomposition:
- Package scan_test_pkg holds:
  - state enum: IDLE, SHIFT, CAPTURE, UNLOAD, WAIT_BIST, DONE
  - default LFSR/MISR polynomials and seed
  - 16-bit signature width constant
- One sub-module, scan_misr: 16-bit MISR with enable, clear and serial input, parameterised by polynomial. The pattern LFSR stays inline.

Test Plan:
- Reset: hold rst=0 for 2 cycles, then release -> all outputs 0, state IDLE; start held low keeps the block idle indefinitely.
- Pattern sequence: pulse start at defaults -> scan_en pattern is 4 high, 1 low, repeated 8 times, then 4 high. scan_in for pattern 0 is 1,0,0,0 (LSBs of 16'hACE1). WAIT_BIST is entered 44 cycles after the first SHIFT.
- Pass: drive scan_out from a reference chain model, set GOLDEN_SIG from the model, raise bist_done=1 with bist_fail=0 at WAIT_BIST cycle 10 -> done=1, pass=1, pattern_cnt=8.
- Signature mismatch: flip one scan_out bit during pattern 3 shift -> done=1, pass=0, signature differs from GOLDEN_SIG.
- BIST fail and timeout: bist_done=1 with bist_fail=1 -> pass=0. In a second run, bist_done is never raised -> DONE entered after exactly 255 WAIT_BIST cycles with pass=0.
- Reset and restart: drop rst during pattern 5 -> scan_en=0 and busy=0 immediately, with no done. Pulse start again while busy -> ignored. A new start from DONE -> clean rerun giving an identical signature.
